pgm_rom_sequencer: RTL
======================

Name: pgm_rom_sequencer

Overview:
- Owns the single-port program ROM shared between the bridge data loader's write path and the AVR core's instruction fetch.
- Sequences each load: optional erase sweep, word writes, reset hold, then CPU release.
- Holds the core in reset while the ROM is being changed, and tracks word count and checksum for the host.
- Runs entirely in the AVR clock domain; the loader's write requests arrive already synchronised into this domain.

Parameters:
- ROM_ADDR_WIDTH, 14: word address width; depth = 2^ROM_ADDR_WIDTH 16-bit words.
- HOLD_CYCLES, 16: cycles cpu_rst stays high after load_end, before RUN.
- CLEAR_ON_LOAD, 1: when 1, load_start first erases the whole ROM.
- CLEAR_VALUE, 16'hFFFF: erase fill word (erased-flash value).

Ports:
- clk  in  1  AVR core clock (clk_avr_16 domain).
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle pulse: begin a new load.
- load_end  in  1  one-cycle pulse: loader finished.
- wr_req  in  1  loader write request; held until wr_ack.
- wr_addr  in  ROM_ADDR_WIDTH  loader word address.
- wr_data  in  16  loader word.
- wr_ack  out  1  one-cycle pulse: request consumed.
- cpu_addr  in  ROM_ADDR_WIDTH  core fetch address (pgm_addr).
- cpu_data  out  16  core fetch data (pgm_data).
- cpu_rst  out  1  core/device reset to atmega32u4_arduboy.
- mem_addr  out  ROM_ADDR_WIDTH  ROM address.
- mem_we  out  1  ROM write enable.
- mem_wdata  out  16  ROM write data.
- mem_rdata  in  16  ROM read data, 1-cycle registered latency.
- words_loaded  out  ROM_ADDR_WIDTH+1  accepted writes since load_start.
- checksum  out  16  sum of accepted wr_data, mod 2^16.
- wr_dropped  out  1  sticky: a write was acked but discarded.
- running  out  1  high in RUN.

Behaviour:
- Reset: state IDLE; cpu_rst=1, running=0, wr_ack=0, mem_we=0, words_loaded=0, checksum=0, wr_dropped=0, clear counter=0, pending_end=0.
- States: IDLE, CLEAR, LOAD, HOLD, RUN.
- load_start, any state: next state is CLEAR if CLEAR_ON_LOAD=1, else LOAD.
  - Zeroes words_loaded, checksum, wr_dropped, pending_end and the clear counter; cpu_rst=1 from the next cycle.
  - load_start outranks every other event in the same cycle.
- CLEAR:
  - mem_we=1, mem_wdata=CLEAR_VALUE, mem_addr=counter, counting 0..2^ROM_ADDR_WIDTH-1, one word per cycle.
  - After the last address, go to LOAD.
  - wr_req is stalled: no ack, no write.
  - load_end sets pending_end.
- LOAD:
  - A write is accepted when wr_req=1 and wr_ack=0. That cycle: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data; wr_ack=1 next cycle.
  - Consequence: at most one write every 2 cycles, and a req held one cycle past ack is never written twice.
  - Each accepted write: words_loaded+1, saturating at 2^ROM_ADDR_WIDTH; checksum+=wr_data, wrapping.
  - load_end, or pending_end on LOAD entry, goes to HOLD. A write accepted in the same cycle as load_end is still performed and counted.
- HOLD:
  - Counts HOLD_CYCLES cycles with cpu_rst=1, then goes to RUN.
  - HOLD_CYCLES=0 goes to RUN on the next cycle.
- RUN: cpu_rst=0, running=1.
- wr_req in IDLE/HOLD/RUN: acked with the same one-cycle ack rule, no mem write, wr_dropped set.
- load_end outside LOAD/CLEAR: ignored.
- Read path, when not writing: mem_addr=cpu_addr. cpu_data=mem_rdata when the previous cycle's state was RUN, else 16'h0000 (NOP).
- ROM write port is single-port; it is written only by this block.

Test Plan:
- Reset with ROM_ADDR_WIDTH=4 -> cpu_rst=1, running=0, wr_ack=0, mem_we=0, cpu_data=0000; state stays IDLE for 100 cycles.
- ROM_ADDR_WIDTH=4, load_start -> 16 consecutive cycles mem_we=1, addr 0..15, data FFFF; wr_req asserted during the sweep gets no ack until LOAD.
- In LOAD, write {0:1234, 1:0FFF, 2:F000}, req held through ack -> exactly 3 mem_we pulses, words_loaded=3, checksum=0x1233.
- load_end with HOLD_CYCLES=16 -> cpu_rst high exactly 16 more cycles, then 0. Fetch addr 1 in RUN -> cpu_data=0FFF one cycle later.
- wr_req in RUN -> wr_ack pulse, mem_we=0, wr_dropped=1, ROM unchanged. Then load_start -> cpu_rst=1 next cycle, wr_dropped=0, CLEAR restarts at addr 0.
- load_end during CLEAR -> pending_end honoured: LOAD lasts 1 cycle, then HOLD; words_loaded=0.

Source files
------------

// File: rtl/pgm_rom_sequencer_if.sv
// Loader write port of the program ROM sequencer.
//   wr_req   loader -> sequencer  write request, held until wr_ack
//   wr_addr  loader -> sequencer  word address
//   wr_data  loader -> sequencer  16-bit word
//   wr_ack   sequencer -> loader  one-cycle pulse, request consumed
interface pgm_rom_sequencer_if #(
    parameter int unsigned ROM_ADDR_WIDTH = 14
);
    logic                      wr_req;
    logic [ROM_ADDR_WIDTH-1:0] wr_addr;
    logic [15:0]               wr_data;
    logic                      wr_ack;

    modport master (output wr_req, output wr_addr, output wr_data, input  wr_ack);
    modport slave  (input  wr_req, input  wr_addr, input  wr_data, output wr_ack);
endinterface

// File: rtl/pgm_rom_sequencer.sv
// Program ROM sequencer (clk_avr_16 domain).
// Owns the single-port program ROM shared by the loader write path and the
// AVR instruction fetch. Each load runs: optional erase sweep, word writes,
// reset hold, CPU release. The core is held in reset while the ROM changes.
// Ports:
//   clk, rst         AVR clock, synchronous active-high reset
//   load_start       pulse: begin a new load (outranks everything)
//   load_end         pulse: loader finished
//   wr               loader write port (wr_req/wr_addr/wr_data/wr_ack)
//   cpu_addr/data    core fetch address / data (NOP while not running)
//   cpu_rst          core reset, high except in RUN
//   mem_*            ROM port; mem_rdata has 1-cycle registered latency
//   words_loaded     accepted writes since load_start (saturating)
//   checksum         16-bit wrapping sum of accepted words
//   wr_dropped       sticky: a write was acked but discarded
//   running          high in RUN
module pgm_rom_sequencer #(
    parameter int unsigned ROM_ADDR_WIDTH = 14,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter bit          CLEAR_ON_LOAD  = 1'b1,
    parameter logic [15:0] CLEAR_VALUE    = 16'hFFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic                      load_end,
    pgm_rom_sequencer_if.slave        wr,
    input  logic [ROM_ADDR_WIDTH-1:0] cpu_addr,
    output logic [15:0]               cpu_data,
    output logic                      cpu_rst,
    output logic [ROM_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_we,
    output logic [15:0]               mem_wdata,
    input  logic [15:0]               mem_rdata,
    output logic [ROM_ADDR_WIDTH:0]   words_loaded,
    output logic [15:0]               checksum,
    output logic                      wr_dropped,
    output logic                      running
);
    localparam int unsigned AW  = ROM_ADDR_WIDTH;
    localparam int unsigned WLW = ROM_ADDR_WIDTH + 1;
    localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
    localparam logic [WLW-1:0] WORDS_MAX = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_HOLD,
        ST_RUN
    } state_t;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic [HCW-1:0]  hold_cnt;
    logic            pending_end;
    logic            wr_ack_q;
    logic            prev_run;
    logic            accept;
    logic            drop;

    assign wr.wr_ack = wr_ack_q;

    // A request is consumed only while wr_ack is low, so a request held one
    // cycle past its ack is never taken twice. CLEAR stalls the loader.
    always_comb begin
        accept = 1'b0;
        drop   = 1'b0;
        if (!load_start && wr.wr_req && !wr_ack_q) begin
            accept = (state == ST_LOAD);
            drop   = (state == ST_IDLE) || (state == ST_HOLD) || (state == ST_RUN);
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = '0;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_cnt;
            mem_wdata = CLEAR_VALUE;
        end else if (accept) begin
            mem_we    = 1'b1;
            mem_addr  = wr.wr_addr;
            mem_wdata = wr.wr_data;
        end
    end

    // ROM data belongs to the address presented one cycle earlier, so it is
    // only forwarded when that cycle was RUN; otherwise the core sees NOPs.
    assign cpu_data = prev_run ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cpu_rst      <= 1'b1;
            running      <= 1'b0;
            wr_ack_q     <= 1'b0;
            words_loaded <= '0;
            checksum     <= '0;
            wr_dropped   <= 1'b0;
            clr_cnt      <= '0;
            hold_cnt     <= '0;
            pending_end  <= 1'b0;
            prev_run     <= 1'b0;
        end else begin
            prev_run <= (state == ST_RUN);
            wr_ack_q <= accept | drop;
            if (drop) begin
                wr_dropped <= 1'b1;
            end
            if (accept) begin
                if (words_loaded != WORDS_MAX) begin
                    words_loaded <= words_loaded + WLW'(1);
                end
                checksum <= checksum + wr.wr_data;
            end

            if (load_start) begin
                state        <= CLEAR_ON_LOAD ? ST_CLEAR : ST_LOAD;
                words_loaded <= '0;
                checksum     <= '0;
                wr_dropped   <= 1'b0;
                pending_end  <= 1'b0;
                clr_cnt      <= '0;
                hold_cnt     <= '0;
                cpu_rst      <= 1'b1;
                running      <= 1'b0;
            end else begin
                case (state)
                    ST_CLEAR: begin
                        clr_cnt <= clr_cnt + AW'(1);
                        if (load_end) begin
                            pending_end <= 1'b1;
                        end
                        if (clr_cnt == '1) begin
                            state <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        // A write accepted alongside load_end is still
                        // performed above; only the state moves on.
                        if (load_end || pending_end) begin
                            pending_end <= 1'b0;
                            hold_cnt    <= '0;
                            if (HOLD_CYCLES == 0) begin
                                state   <= ST_RUN;
                                cpu_rst <= 1'b0;
                                running <= 1'b1;
                            end else begin
                                state <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state   <= ST_RUN;
                            cpu_rst <= 1'b0;
                            running <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + HCW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule
